// File: rtl/mips_cpu_bus_master_if.sv
// Request/response bundle between the CPU core and the bus master, plus the
// Avalon-MM master signals the block drives toward memory.
interface mips_cpu_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [NB-1:0]     byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  waitrequest, readdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output waitrequest, readdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_bus_master.sv
// Single-outstanding Avalon-MM master for the MIPS core: lane steering,
// load extension, alignment checking and optional waitrequest timeout.
module mips_cpu_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mips_cpu_bus_master_if.master   bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);
  localparam int OFS_S = (OFS_W > 0) ? OFS_W : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] address_q;
  logic              read_q, write_q;
  logic [DATA_W-1:0] writedata_q;
  logic [NB-1:0]     byteenable_q;
  logic              rsp_valid_q, rsp_error_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [OFS_S-1:0]  ofs_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [OFS_S-1:0]  ofs_s;
  logic              fault_s;
  logic [NB-1:0]     be_s;
  logic [DATA_W-1:0] lane_mask_s;
  logic [DATA_W-1:0] wd_s;
  logic [DATA_W-1:0] load_s;
  logic              timeout_s;

  // Truncate the lane-shifted load data to the access size, then extend.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] sz,
                                                    input logic sgn);
    logic [DATA_W-1:0] r;
    int nbits;
    r = d;
    for (int s = 0; s < OFS_W; s++) begin
      if (sz == 2'(s)) begin
        nbits = 8 << s;
        for (int b = 0; b < DATA_W; b++) begin
          if (b >= nbits) r[b] = sgn & d[nbits-1];
          else            r[b] = d[b];
        end
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign ofs_s       = OFS_S'(bus.req_addr & ADDR_W'(NB - 1));
  assign load_s      = extend_load(bus.readdata >> {ofs_q, 3'b000}, size_q, signed_q);
  assign wd_s        = (bus.req_wdata << {ofs_s, 3'b000}) & lane_mask_s;
  assign timeout_s   = (TIMEOUT > 0) && (32'(cnt_q) == TIMEOUT - 1);
  assign fault_s     = (32'(bus.req_size) > OFS_W) ||
                       ((bus.req_addr & ADDR_W'((32'd1 << bus.req_size) - 32'd1))
                        != {ADDR_W{1'b0}});

  // Byte enables and the matching bit mask for the incoming request.
  always_comb begin
    be_s        = {NB{1'b0}};
    lane_mask_s = {DATA_W{1'b0}};
    for (int b = 0; b < NB; b++) begin
      be_s[b] = (b >= int'(ofs_s)) && (b < int'(ofs_s) + (1 << bus.req_size));
      lane_mask_s[8*b +: 8] = {8{be_s[b]}};
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && reset_n;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      address_q    <= {ADDR_W{1'b0}};
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= {DATA_W{1'b0}};
      byteenable_q <= {NB{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= {DATA_W{1'b0}};
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      ofs_q        <= {OFS_S{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (fault_s) begin
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= {DATA_W{1'b0}};
              state_q     <= RESP;
            end else begin
              address_q    <= bus.req_addr & ~ADDR_W'(NB - 1);
              byteenable_q <= be_s;
              writedata_q  <= wd_s;
              read_q       <= ~bus.req_write;
              write_q      <= bus.req_write;
              size_q       <= bus.req_size;
              signed_q     <= bus.req_signed;
              ofs_q        <= ofs_s;
              cnt_q        <= {CNT_W{1'b0}};
              state_q      <= BUS;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= read_q ? load_s : {DATA_W{1'b0}};
            state_q     <= RESP;
          end else if (timeout_s) begin
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= {DATA_W{1'b0}};
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= {DATA_W{1'b0}};
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed vector bench for mips_cpu_bus_master (32-bit bus, TIMEOUT=4).
module tb_mips_cpu_bus_master;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cur;

  mips_cpu_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_cpu_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", nm, cur, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid   = 1'b1;
    bus.req_write   = v.wr;
    bus.req_addr    = v.addr;
    bus.req_size    = v.size;
    bus.req_signed  = v.sgn;
    bus.req_wdata   = v.wdata;
    bus.readdata    = v.rdata;
    bus.waitrequest = (v.waits > 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (v.err) begin
      chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("err_rsp_error", 32'(bus.rsp_error), 32'd1);
      chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("err_no_strobe", {30'd0, bus.read, bus.write}, 32'd0);
      @(posedge clk); #1;
      chk("err_rsp_drop", 32'(bus.rsp_valid), 32'd0);
      chk("err_no_strobe2", {30'd0, bus.read, bus.write}, 32'd0);
    end else begin
      chk("address", bus.address, v.e_addr);
      chk("byteenable", 32'(bus.byteenable), 32'(v.e_be));
      chk("strobes", {30'd0, bus.read, bus.write}, {30'd0, ~v.wr, v.wr});
      if (v.wr) chk("writedata", bus.writedata, v.e_wd);
      chk("rsp_early", 32'(bus.rsp_valid), 32'd0);
      for (int k = 1; k <= v.waits; k++) begin
        @(posedge clk); #1;
        bus.waitrequest = (k < v.waits);
        chk("stall_address", bus.address, v.e_addr);
        chk("stall_be", 32'(bus.byteenable), 32'(v.e_be));
        chk("stall_strobes", {30'd0, bus.read, bus.write}, {30'd0, ~v.wr, v.wr});
        if (v.wr) chk("stall_writedata", bus.writedata, v.e_wd);
        chk("stall_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_error", 32'(bus.rsp_error), 32'd0);
      chk("rsp_rdata", bus.rsp_rdata, v.e_rd);
      chk("strobes_off", {30'd0, bus.read, bus.write}, 32'd0);
      @(posedge clk); #1;
      chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    int hi;
    bit seen;
    checks = 0;
    errors = 0;
    cur    = -1;

    //                wr    addr          sz    sgn   wdata          rdata         W  err   e_addr        e_be     e_wd           e_rd
    vecs[0] = '{1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0103, 2'd0, 1'b1, 32'h0,         32'h8011_2233, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[2] = '{1'b0, 32'h0000_0103, 2'd0, 1'b0, 32'h0,         32'h8011_2233, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080};
    vecs[3] = '{1'b1, 32'h0000_0102, 2'd1, 1'b0, 32'h1234_ABCD, 32'h5555_5555, 3, 1'b0, 32'h0000_0100, 4'b1100, 32'hABCD_0000, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'h0,         32'h1111_1111, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 32'h0000_0100, 2'd3, 1'b0, 32'h0,         32'h1111_1111, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
    vecs[6] = '{1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0,         32'h8001_7FFF, 1, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8001};
    vecs[7] = '{1'b1, 32'h0000_0205, 2'd0, 1'b0, 32'hAABB_CC77, 32'h0,         0, 1'b0, 32'h0000_0204, 4'b0010, 32'h0000_7700, 32'h0};
    vecs[8] = '{1'b0, 32'h0000_0200, 2'd1, 1'b0, 32'h0,         32'h1234_F00D, 2, 1'b0, 32'h0000_0200, 4'b0011, 32'h0,         32'h0000_F00D};
    vecs[9] = '{1'b0, 32'h0000_0201, 2'd1, 1'b0, 32'h0,         32'h1234_F00D, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};

    reset_n         = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = 32'h0;
    bus.req_size    = 2'd0;
    bus.req_signed  = 1'b0;
    bus.req_wdata   = 32'h0;
    bus.waitrequest = 1'b0;
    bus.readdata    = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_strobes", {30'd0, bus.read, bus.write}, 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_be", 32'(bus.byteenable), 32'd0);
    chk("rst_wd", bus.writedata, 32'd0);
    chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_error}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    // Waitrequest stuck high: abort after exactly four strobe cycles.
    cur = 100;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b0;
    bus.req_addr    = 32'h0000_0300;
    bus.req_size    = 2'd2;
    bus.req_signed  = 1'b0;
    bus.readdata    = 32'hCAFE_F00D;
    bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    hi   = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.read) hi++;
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_read_cycles", 32'(hi), 32'd4);
    chk("to_error", 32'(bus.rsp_error), 32'd1);
    chk("to_rdata", bus.rsp_rdata, 32'd0);
    chk("to_read_off", 32'(bus.read), 32'd0);
    bus.waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("to_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // Asynchronous reset in the middle of a stalled write.
    cur = 101;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b1;
    bus.req_addr    = 32'h0000_0102;
    bus.req_size    = 2'd1;
    bus.req_wdata   = 32'h1234_ABCD;
    bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rs_write_up", 32'(bus.write), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rs_write_drop", 32'(bus.write), 32'd0);
    chk("rs_be_drop", 32'(bus.byteenable), 32'd0);
    chk("rs_wd_drop", bus.writedata, 32'd0);
    chk("rs_ready_low", 32'(bus.req_ready), 32'd0);
    chk("rs_no_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rs_no_rsp_hold", 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    reset_n         = 1'b1;
    bus.waitrequest = 1'b0;
    #1;
    chk("rs_ready_release", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rs_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    cur = 102;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
